// File: rtl/axi4l_regfile.sv
// AXI4-Lite slave register file: byte-strobed RW registers, live read-only inputs,
// independent read and write state machines returning OKAY/SLVERR/DECERR.
`timescale 1ns/1ps
module axi4l_regfile #(
  parameter int                            ADDR_WIDTH = 12,
  parameter int                            DATA_WIDTH = 32,
  parameter int                            NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int REG_IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("axi4l_regfile: DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t                w_state;
  r_state_t                r_state;
  logic [DATA_WIDTH-1:0]   regs     [NUM_REGS];
  logic [DATA_WIDTH-1:0]   reg_in_a [NUM_REGS];
  logic [IDX_W-1:0]        aw_idx;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    aw_held;
  logic                    w_held;
  logic [IDX_W-1:0]        ar_idx;
  logic [REG_IW-1:0]       aw_sel;
  logic [REG_IW-1:0]       ar_sel;
  logic                    aw_hit;
  logic                    ar_hit;
  logic                    unused_bits;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    assign reg_in_a[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign ar_idx = araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_sel = aw_idx[REG_IW-1:0];
  assign ar_sel = ar_idx[REG_IW-1:0];
  assign aw_hit = {1'b0, aw_idx} < NUM_REGS_C;
  assign ar_hit = {1'b0, ar_idx} < NUM_REGS_C;
  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_bits = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            w_state <= W_RESP;
            if (!aw_hit) begin
              bresp <= RESP_DECERR;
            end else if (RO_MASK[aw_sel]) begin
              bresp <= RESP_SLVERR;
            end else begin
              bresp            <= RESP_OKAY;
              wr_pulse[aw_sel] <= 1'b1;
              for (int k = 0; k < STRB_W; k++)
                if (wstrb_q[k]) regs[aw_sel][8*k +: 8] <= wdata_q[8*k +: 8];
            end
          end else begin
            if (awready && awvalid) begin
              aw_idx  <= awaddr[ADDR_WIDTH-1:ADDR_LSB];
              aw_held <= 1'b1;
              awready <= 1'b0;
            end else if (!aw_held) begin
              awready <= 1'b1;
            end
            if (wready && wvalid) begin
              wdata_q <= wdata;
              wstrb_q <= wstrb;
              w_held  <= 1'b1;
              wready  <= 1'b0;
            end else if (!w_held) begin
              wready <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Reads see pre-commit register values because regs update on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready && arvalid) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            r_state <= R_DATA;
            if (!ar_hit) begin
              rdata <= '0;
              rresp <= RESP_DECERR;
            end else begin
              rdata <= RO_MASK[ar_sel] ? reg_in_a[ar_sel] : regs[ar_sel];
              rresp <= RESP_OKAY;
            end
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
